// File: rtl/mb_seq_multiplier.sv
// rtl/mb_seq_multiplier.sv - sequential radix-4 modified-Booth multiplier, one digit per clock
// Optional unsigned mode is compiled in with MB_UNSIGNED_EN.
module mb_seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef MB_UNSIGNED_EN
    input  logic           uns,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int W  = 2 * N;
    localparam int BW = N + 3;
    localparam int DS = N / 2;
    localparam int DU = N / 2 + 1;
    localparam int CW = $clog2(DU + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  mc;
    logic [BW-1:0] bsh;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    logic          bm, bz, bp;
    logic          sgn, one, two;
    logic [W-1:0]  mag;
    logic [W-1:0]  pp;
    logic [W-1:0]  sum;

    // mc is pre-shifted by 2i and bsh by 2i, so the current digit is always bsh[2:0]
    always_comb begin
        bm  = bsh[0];
        bz  = bsh[1];
        bp  = bsh[2];
        sgn = bp & ~(bp & bz & bm);
        one = bm ^ bz;
        two = ~one & (bp ^ bz);
        mag = '0;
        if (two)
            mag = {mc[W-2:0], 1'b0};
        else if (one)
            mag = mc;
        pp  = sgn ? ('0 - mag) : mag;
        sum = acc + pp;
    end

`ifdef MB_UNSIGNED_EN
    always_ff @(posedge clk) begin
        if (rst)
            last <= '0;
        else if (state == IDLE && start)
            last <= uns ? CW'(DU - 1) : CW'(DS - 1);
    end
`else
    assign last = CW'(DS - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            mc    <= '0;
            bsh   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef MB_UNSIGNED_EN
                        if (uns) begin
                            mc  <= {{N{1'b0}}, a};
                            bsh <= {2'b00, b, 1'b0};
                        end else begin
                            mc  <= {{N{a[N-1]}}, a};
                            bsh <= {{2{b[N-1]}}, b, 1'b0};
                        end
`else
                        mc  <= {{N{a[N-1]}}, a};
                        bsh <= {{2{b[N-1]}}, b, 1'b0};
`endif
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    mc  <= {mc[W-3:0], 2'b00};
                    bsh <= {2'b00, bsh[BW-1:2]};
                    cnt <= cnt + CW'(1);
                    if (cnt == last) begin
                        p     <= sum;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
